// File: rtl/pc_circuit_pkg.sv
// Shared constants and types for the program counter block.
// Widths and reset value live here so the register and mux stay consistent.
package pc_circuit_pkg;

  localparam int unsigned PC_WIDTH    = 16;
  localparam int unsigned LABEL_WIDTH = 11;
  localparam int unsigned PAGE_WIDTH  = PC_WIDTH - LABEL_WIDTH;

  localparam logic [PC_WIDTH-1:0] RESET_PC = 16'h0000;

  typedef enum logic {
    SRC_LOAD = 1'b0,
    SRC_JUMP = 1'b1
  } pc_src_e;

endpackage : pc_circuit_pkg

// File: rtl/pc_circuit_if.sv
// Update/readback bundle for the program counter.
// The controller drives the update request; the PC block returns Q.
interface pc_circuit_if;
  import pc_circuit_pkg::*;

  logic                   PC_E;
  logic                   ctrl_PC;
  logic [PC_WIDTH-1:0]    D;
  logic [LABEL_WIDTH-1:0] PC_label;
  logic [PC_WIDTH-1:0]    Q;

  modport master (
    output PC_E,
    output ctrl_PC,
    output D,
    output PC_label,
    input  Q
  );

  modport slave (
    input  PC_E,
    input  ctrl_PC,
    input  D,
    input  PC_label,
    output Q
  );

endinterface : pc_circuit_if

// File: rtl/pc_circuit_pc_reg.sv
// PC storage register: async active-high reset to RESET_PC, synchronous enable.
module pc_reg
  import pc_circuit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] d,
  output logic [PC_WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pc_reg

// File: rtl/pc_circuit.sv
// Program counter with full load from D or page-relative jump to a label.
// No auto-increment: the PC only moves when PC_E is asserted.
module pc_circuit
  import pc_circuit_pkg::*;
(
  input  logic        CLK,
  input  logic        rst_n,
  pc_circuit_if.slave bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  pc_src_e             src;

  assign src = pc_src_e'(bus.ctrl_PC);

  // A jump keeps the current page bits; the label never carries into them.
  always_comb begin
    pc_next = bus.D;
    if (src == SRC_JUMP) begin
      pc_next = {pc_q[PC_WIDTH-1:LABEL_WIDTH], bus.PC_label};
    end
  end

  pc_reg u_pc_reg (
    .clk (CLK),
    .rst (rst_n),
    .en  (bus.PC_E),
    .d   (pc_next),
    .q   (pc_q)
  );

  assign bus.Q = pc_q;

endmodule : pc_circuit

// File: tb/tb_pc_circuit.sv
// Self-checking bench for pc_circuit: directed vector table, reset sequences
// and a short randomized load/jump loop against a reference model.
module tb_pc_circuit;
  import pc_circuit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  pc_circuit_if pc_if ();

  pc_circuit dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (pc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string                  name;
    logic                   pe;
    logic                   ctrl;
    logic [PC_WIDTH-1:0]    d;
    logic [LABEL_WIDTH-1:0] label;
    logic [PC_WIDTH-1:0]    exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [PC_WIDTH-1:0] act,
                       input logic [PC_WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: Q=%h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge.
  task automatic step(input logic pe, input logic ctrl,
                      input logic [PC_WIDTH-1:0] d,
                      input logic [LABEL_WIDTH-1:0] label);
    @(negedge clk);
    pc_if.PC_E     = pe;
    pc_if.ctrl_PC  = ctrl;
    pc_if.D        = d;
    pc_if.PC_label = label;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PC_WIDTH-1:0]    rd;
    logic [LABEL_WIDTH-1:0] rl;
    logic [PC_WIDTH-1:0]    model;

    n_checks = 0;
    n_pass   = 0;

    rst_n          = 1'b1;
    pc_if.PC_E     = 1'b1;
    pc_if.ctrl_PC  = 1'b0;
    pc_if.D        = 16'hBEEF;
    pc_if.PC_label = 11'h000;
    #1;
    check("reset_async_at_start", pc_if.Q, 16'h0000);

    // Reset dominates an active load request over two edges.
    step(1'b1, 1'b0, 16'hBEEF, 11'h123);
    check("reset_edge1", pc_if.Q, 16'h0000);
    step(1'b1, 1'b1, 16'hBEEF, 11'h7FF);
    check("reset_edge2", pc_if.Q, 16'h0000);

    @(negedge clk);
    rst_n      = 1'b0;
    pc_if.PC_E = 1'b0;

    vecs.push_back('{"load_3524",     1'b1, 1'b0, 16'h3524, 11'h000, 16'h3524});
    vecs.push_back('{"load_d609",     1'b1, 1'b0, 16'hD609, 11'h7FF, 16'hD609});
    vecs.push_back('{"jump_263",      1'b1, 1'b1, 16'hFFFF, 11'h263, 16'hD263});
    vecs.push_back('{"load_f800",     1'b1, 1'b0, 16'hF800, 11'h000, 16'hF800});
    vecs.push_back('{"jump_7ff",      1'b1, 1'b1, 16'h0000, 11'h7FF, 16'hFFFF});
    vecs.push_back('{"load_1234",     1'b1, 1'b0, 16'h1234, 11'h000, 16'h1234});
    vecs.push_back('{"hold_ctrl1",    1'b0, 1'b1, 16'hFFFF, 11'h555, 16'h1234});
    vecs.push_back('{"hold_ctrl0",    1'b0, 1'b0, 16'hFFFF, 11'h555, 16'h1234});
    vecs.push_back('{"hold_ctrl1_b",  1'b0, 1'b1, 16'hFFFF, 11'h555, 16'h1234});
    vecs.push_back('{"load_8801",     1'b1, 1'b0, 16'h8801, 11'h7FF, 16'h8801});
    vecs.push_back('{"jump_000",      1'b1, 1'b1, 16'h0000, 11'h000, 16'h8800});
    vecs.push_back('{"jump_7ff_nocy", 1'b1, 1'b1, 16'h0000, 11'h7FF, 16'h8FFF});
    vecs.push_back('{"jump_again",    1'b1, 1'b1, 16'h0000, 11'h001, 16'h8801});
    vecs.push_back('{"load_zero",     1'b1, 1'b0, 16'h0000, 11'h7FF, 16'h0000});

    foreach (vecs[i]) begin
      step(vecs[i].pe, vecs[i].ctrl, vecs[i].d, vecs[i].label);
      check(vecs[i].name, pc_if.Q, vecs[i].exp);
    end

    // Mid-operation reset: asserted between edges, must clear Q immediately.
    step(1'b1, 1'b0, 16'hA5A5, 11'h000);
    check("midrst_preload", pc_if.Q, 16'hA5A5);
    @(negedge clk);
    pc_if.PC_E = 1'b1;
    pc_if.D    = 16'h7777;
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_async_clear", pc_if.Q, 16'h0000);
    @(posedge clk);
    #1;
    check("midrst_held", pc_if.Q, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 16'h0042, 11'h000);
    check("midrst_release_load", pc_if.Q, 16'h0042);

    // Randomized load followed by page-relative jump.
    for (int it = 0; it < 10; it++) begin
      rd = 16'($urandom_range(0, 16'hFFFF));
      rl = 11'($urandom_range(0, 11'h7FF));
      step(1'b1, 1'b0, rd, ~rl);
      check($sformatf("rand_load_%0d", it), pc_if.Q, rd);
      model = {rd[PC_WIDTH-1:LABEL_WIDTH], rl};
      step(1'b1, 1'b1, ~rd, rl);
      check($sformatf("rand_jump_%0d", it), pc_if.Q, model);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule : tb_pc_circuit

// File: doc/pc_circuit.md
PC_CIRCUIT -- requirements
Module: pc_circuit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-high: 1 = reset asserted (codebase port name retained despite the suffix).
REQ-004 PC_E  input  1  PC update enable; 0 = hold.
REQ-005 ctrl_PC  input  1  update source select: 0 = full load from D; 1 = jump to label.
REQ-006 D  input  16  full load value for the PC.
REQ-007 PC_label  input  11  jump target; replaces PC bits [10:0].
REQ-008 Q  output  16  current PC value, driven directly from the PC register (no combinational path from inputs).

Function
REQ-009 The PC SHALL be a single 16-bit register; Q SHALL equal the register value at all times.
REQ-010 On a rising CLK edge with rst_n=0, PC_E=1, ctrl_PC=0: the register SHALL load D.
REQ-011 On a rising CLK edge with rst_n=0, PC_E=1, ctrl_PC=1: the register SHALL load {PC[15:11], PC_label[10:0]}; upper 5 bits are preserved from the current PC (page-relative jump).
REQ-012 On a rising CLK edge with PC_E=0: the register SHALL hold, regardless of ctrl_PC, D and PC_label.
REQ-013 Latency SHALL be one cycle: Q reflects the new value after the edge that samples PC_E=1.
REQ-014 There SHALL be no auto-increment; the PC changes only through REQ-010/011.
REQ-015 Back-to-back updates (PC_E=1 on consecutive edges) SHALL each take effect; a jump after a load SHALL use the upper bits of the just-loaded value.
REQ-016 Label width arithmetic: no carry or overflow into bit 11; a label of 11'h7FF SHALL give PC[10:0]=0x7FF with PC[15:11] unchanged.
REQ-017 X/Z inputs are out of scope; the design need not define behaviour for them.

Reset
REQ-018 rst_n=1 SHALL force Q=16'h0000 immediately, without waiting for a clock edge.
REQ-019 While rst_n=1, the register SHALL stay at 0x0000 regardless of PC_E, ctrl_PC, D and PC_label.
REQ-020 Reset asserted mid-operation SHALL override any pending update; after rst_n falls to 0, the first rising edge with PC_E=1 SHALL update normally.

Structure
REQ-021 A shared package SHALL hold PC_WIDTH=16, LABEL_WIDTH=11 and RESET_PC=16'h0000; the block SHALL use these constants instead of literal widths.
REQ-022 The next-value mux (D vs {PC[15:11],label}) SHALL reside in pc_circuit.
REQ-023 The block SHALL use one sub-module, pc_reg: a PC_WIDTH register with async active-high reset to RESET_PC and a synchronous enable.

Verification
REQ-024 Reset: rst_n=1, PC_E=1, D=0xBEEF, run 2 edges -> Q=0x0000 throughout; Q reaches 0 asynchronously when rst_n rises.
REQ-025 Load: rst_n=0, PC_E=1, ctrl_PC=0, D=0x3524 -> Q=0x3524 after one edge.
REQ-026 Jump: PC=0xD609, PC_E=1, ctrl_PC=1, PC_label=0x263 -> Q=0xD263 (upper 5 bits kept); with PC=0xF800, label=0x7FF -> Q=0xFFFF.
REQ-027 Hold: PC=0x1234, PC_E=0, ctrl_PC toggled, D=0xFFFF, label=0x555 -> Q stays 0x1234 over 3 edges.
REQ-028 Mid-operation reset: PC=0xA5A5, assert rst_n=1 between edges -> Q=0x0000 at once; release, load D=0x0042 -> Q=0x0042 after one edge.
REQ-029 Random: 10 iterations of random 16-bit load followed by random 11-bit jump, each checked against the model {prev[15:11], label} -> zero mismatches.
